multicycle_chunk_adder: RTL and testbench

- Parametrised, multi-cycle add/subtract unit built on the full-adder primitive.
- Computes a WIDTH-bit sum CHUNK bits per clock, carry held in a register between chunks.
- Start/done handshake; used by datapath blocks that trade latency for a narrow adder slice.
- Adds subtract mode, signed-overflow and zero flags, and registered, stable results.

---
 rtl/multicycle_chunk_adder.sv | 145 ++++++++++++++
 tb/tb_multicycle_chunk_adder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_chunk_adder.sv
// Multi-cycle add/subtract unit: ripples CHUNK full-adder bits per clock,
// keeping the inter-chunk carry in a register, with a start/done handshake.
module multicycle_chunk_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             Ofl,
   output logic             Zero
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_DONE
   } state_t;

   state_t              state_q;
   logic [WIDTH-1:0]    a_q;
   logic [WIDTH-1:0]    b_q;
   logic [WIDTH-1:0]    psum_q;
   logic                carry_q;
   logic [KW-1:0]       k_q;
   logic [WIDTH-1:0]    s_q;
   logic                cout_q;
   logic                ofl_q;
   logic                zero_q;
   logic                busy_q;
   logic                done_q;

   logic [CHUNK-1:0]    a_chunk;
   logic [CHUNK-1:0]    b_chunk;
   logic [CHUNK-1:0]    sum_chunk;
   logic                carry_d;
   logic                carry_msb_in;
   logic [WIDTH-1:0]    psum_d;
   logic                last_chunk;

   function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
      return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
   endfunction

   // One CHUNK-wide ripple slice over the operand chunk selected by k_q.
   always_comb begin
      logic c;
      a_chunk      = '0;
      b_chunk      = '0;
      sum_chunk    = '0;
      carry_msb_in = 1'b0;
      psum_d       = psum_q;
      for (int j = 0; j < NCHUNK; j++) begin
         if (k_q == KW'(j)) begin
            a_chunk = a_q[j*CHUNK +: CHUNK];
            b_chunk = b_q[j*CHUNK +: CHUNK];
         end
      end
      c = carry_q;
      for (int i = 0; i < CHUNK; i++) begin
         if (i == CHUNK - 1) carry_msb_in = c;
         {c, sum_chunk[i]} = full_add(a_chunk[i], b_chunk[i], c);
      end
      carry_d = c;
      for (int j = 0; j < NCHUNK; j++) begin
         if (k_q == KW'(j)) psum_d[j*CHUNK +: CHUNK] = sum_chunk;
      end
      last_chunk = (k_q == KW'(NCHUNK - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         psum_q  <= '0;
         carry_q <= 1'b0;
         k_q     <= '0;
         s_q     <= '0;
         cout_q  <= 1'b0;
         ofl_q   <= 1'b0;
         zero_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  a_q     <= A;
                  b_q     <= B ^ {WIDTH{sub}};
                  carry_q <= sub | Cin;
                  k_q     <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               psum_q  <= psum_d;
               carry_q <= carry_d;
               // Results are published only once the final chunk is in.
               if (last_chunk) begin
                  s_q     <= psum_d;
                  cout_q  <= carry_d;
                  ofl_q   <= carry_msb_in ^ carry_d;
                  zero_q  <= (psum_d == '0);
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end else begin
                  k_q <= k_q + KW'(1);
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign S    = s_q;
   assign Cout = cout_q;
   assign Ofl  = ofl_q;
   assign Zero = zero_q;

endmodule

// File: tb/tb_multicycle_chunk_adder.sv
// Bench for multicycle_chunk_adder: a 16-bit/4-bit-chunk instance and an
// 8-bit single-chunk instance, checked against an arithmetic reference.
module tb_multicycle_chunk_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        start, Cin, sub, busy, done, Cout, Ofl, Zero;
   logic [15:0] A, B, S;
   logic        start8, Cin8, sub8, busy8, done8, Cout8, Ofl8, Zero8;
   logic [7:0]  A8, B8, S8;

   int n_cmp = 0;
   int n_err = 0;

   logic [15:0] prev_s;
   logic        prev_cout, prev_ofl, prev_zero;

   multicycle_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Cin(Cin), .sub(sub),
      .busy(busy), .done(done), .S(S), .Cout(Cout), .Ofl(Ofl), .Zero(Zero)
   );

   multicycle_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .A(A8), .B(B8), .Cin(Cin8), .sub(sub8),
      .busy(busy8), .done(done8), .S(S8), .Cout(Cout8), .Ofl(Ofl8), .Zero(Zero8)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: w-bit modular sum of A and (B or ~B) plus carry-in; returns
   // {cout, ofl, zero, sum}. Overflow taken from operand/result signs.
   function automatic logic [34:0] refm(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sb);
      logic [63:0] mask, aa, bb, full, s;
      logic co, of, z;
      mask = (64'd1 << w) - 64'd1;
      aa   = {32'd0, a} & mask;
      bb   = (sb ? ~{32'd0, b} : {32'd0, b}) & mask;
      full = aa + bb + ((sb || cin) ? 64'd1 : 64'd0);
      s    = full & mask;
      co   = full[w];
      of   = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
      z    = (s == 64'd0);
      return {co, of, z, s[31:0]};
   endfunction

   task automatic scramble16();
      A   = 16'($urandom);
      B   = 16'($urandom);
      Cin = 1'($urandom);
      sub = 1'($urandom);
   endtask

   task automatic check_held(input string tag);
      chk({tag, "_S"},    32'(S),    32'(prev_s));
      chk({tag, "_Cout"}, 32'(Cout), 32'(prev_cout));
      chk({tag, "_Ofl"},  32'(Ofl),  32'(prev_ofl));
      chk({tag, "_Zero"}, 32'(Zero), 32'(prev_zero));
   endtask

   // Called #1 after an edge with the DUT idle; returns #1 after the edge
   // that moves DONE back to IDLE.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic sb, input logic hold_start);
      logic [34:0] r;
      r     = refm(16, 32'(a), 32'(b), cin, sb);
      A     = a;
      B     = b;
      Cin   = cin;
      sub   = sb;
      start = 1'b1;
      @(posedge clk); #1;
      start = hold_start;
      scramble16();
      chk("busy_e0", 32'(busy), 1);
      chk("done_e0", 32'(done), 0);
      check_held("hold_e0");
      repeat (3) begin
         @(posedge clk); #1;
         chk("busy_mid", 32'(busy), 1);
         chk("done_mid", 32'(done), 0);
         check_held("hold_mid");
         scramble16();
      end
      @(posedge clk); #1;
      chk("done_pulse", 32'(done), 1);
      chk("busy_done", 32'(busy), 0);
      chk("S", 32'(S), 32'(r[15:0]));
      chk("Cout", 32'(Cout), 32'(r[34]));
      chk("Ofl", 32'(Ofl), 32'(r[33]));
      chk("Zero", 32'(Zero), 32'(r[32]));
      prev_s    = r[15:0];
      prev_cout = r[34];
      prev_ofl  = r[33];
      prev_zero = r[32];
      scramble16();
      @(posedge clk); #1;
      chk("done_drop", 32'(done), 0);
      chk("busy_idle", 32'(busy), 0);
      check_held("hold_idle");
   endtask

   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sb);
      logic [34:0] r;
      r      = refm(8, 32'(a), 32'(b), cin, sb);
      A8     = a;
      B8     = b;
      Cin8   = cin;
      sub8   = sb;
      start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      A8     = 8'($urandom);
      B8     = 8'($urandom);
      chk("w8_busy", 32'(busy8), 1);
      chk("w8_done_e0", 32'(done8), 0);
      @(posedge clk); #1;
      chk("w8_done", 32'(done8), 1);
      chk("w8_busy_done", 32'(busy8), 0);
      chk("w8_S", 32'(S8), 32'(r[7:0]));
      chk("w8_Cout", 32'(Cout8), 32'(r[34]));
      chk("w8_Ofl", 32'(Ofl8), 32'(r[33]));
      chk("w8_Zero", 32'(Zero8), 32'(r[32]));
      @(posedge clk); #1;
      chk("w8_done_drop", 32'(done8), 0);
      chk("w8_S_hold", 32'(S8), 32'(r[7:0]));
   endtask

   initial begin
      rst_n  = 1'b0;
      start  = 1'b0; A  = '0; B  = '0; Cin  = 1'b0; sub  = 1'b0;
      start8 = 1'b0; A8 = '0; B8 = '0; Cin8 = 1'b0; sub8 = 1'b0;
      prev_s = '0; prev_cout = 1'b0; prev_ofl = 1'b0; prev_zero = 1'b0;
      #12;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      check_held("rst");
      chk("rst_w8_S", 32'(S8), 0);
      chk("rst_w8_busy", 32'(busy8), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
      run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
      run_op(16'h7FFF, 16'h0000, 1'b1, 1'b0, 1'b0);
      run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0);
      run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0);

      // Start held high: each call's accept edge lands six cycles after the last.
      for (int i = 0; i < 4; i++)
         run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      start = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 20; i++)
         run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);

      // Asynchronous reset in the middle of an operation.
      A = 16'h00F0; B = 16'h0F0F; Cin = 1'b0; sub = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 0);
      chk("arst_done", 32'(done), 0);
      chk("arst_S", 32'(S), 0);
      chk("arst_Cout", 32'(Cout), 0);
      chk("arst_Ofl", 32'(Ofl), 0);
      chk("arst_Zero", 32'(Zero), 0);
      @(posedge clk); #1;
      chk("arst_done_hold", 32'(done), 0);
      rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         chk("post_rst_done", 32'(done), 0);
         chk("post_rst_busy", 32'(busy), 0);
      end
      prev_s = '0; prev_cout = 1'b0; prev_ofl = 1'b0; prev_zero = 1'b0;
      run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);

      run8(8'h80, 8'h80, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++)
         run8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
